hazard_halt_unit: RTL and testbench
===================================

# hazard_halt_unit

Pipeline sequencing block for the 5-stage RISC-V core. It consumes the decoded control signals produced in ID and EX, and drives the fetch/decode enables and flush lines. Its three jobs are load-use stall insertion, taken-branch/jump flush, and the halt-opcode drain-and-stop sequence. It sits beside the ID/EX pipeline register and gates the PC, IF/ID and ID/EX registers.

## Interface
Parameters:
- DRAIN_CYCLES, 3, cycles of bubbles issued after a halt is accepted (covers EX, MEM, WB).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_halt  in  1  decoded Halt for the ID instruction.
- id_rs1, id_rs2  in  5  source register indices in ID.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1 / rs2.
- ex_memread  in  1  MemRead of the instruction in EX.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to a bubble.
- idex_flush  out  1  load a bubble (all control zero) into ID/EX.
- halted  out  1  core stopped; sticky until reset.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Outputs are combinational from state and inputs; state, drain counter and stall_count are registered.
- Load-use hazard (lu) = id_valid & ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN priority:
  - ex_redirect: ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1. lu and id_halt are ignored because the ID instruction is wrong-path.
  - else lu: pc_en=0, ifid_en=0, idex_flush=1. stall_count increments. id_halt is ignored this cycle and re-evaluated next cycle.
  - else id_valid & id_halt: pc_en=0, ifid_en=0, idex_flush=1. Next state DRAIN, drain counter loaded with DRAIN_CYCLES-1.
  - else: pc_en=1, ifid_en=1, no flushes.
- DRAIN:
  - Outputs: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
  - Inputs are ignored.
  - Counter decrements each cycle; when it is 0, next state is HALTED.
- HALTED: pc_en=0, ifid_en=0, idex_flush=1, halted=1. Only reset leaves this state.
- stall_count saturates at 2^CNT_W-1. It increments only on RUN-state lu cycles that have no redirect.
- While reset=1:
  - pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, halted=0.
  - Next state RUN, stall_count=0, drain counter=0.

## Timing
- Stall/flush/enable responses are same-cycle (zero latency) to the inputs.
- A halt accepted in cycle N gives DRAIN in cycles N+1..N+DRAIN_CYCLES and halted=1 from cycle N+DRAIN_CYCLES+1.
- A load-use stall lasts exactly one cycle per hazard. Next cycle the load has left EX and ex_memread is for the bubble.
- Reset asserted mid-DRAIN or in HALTED aborts the sequence. The first cycle after reset deasserts is RUN with pc_en=1 (absent hazards).
- DRAIN_CYCLES must be ≥1. DRAIN_CYCLES=1 means halted rises in N+2.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, DRAIN, HALTED);
  - the REG_X0 constant (5'd0);
  - the default DRAIN_CYCLES constant, shared with the testbench.
- Sub-module hazard_detect: combinational lu comparison (rs/rd match, x0 exclusion). Reused later for forwarding checks.

## Test plan
- ex_memread=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, id_valid=1 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle; stall_count 0->1.
- Same as above but ex_rd=0, or id_uses_rs1=0 -> pc_en=1, no flush, stall_count stays 0.
- lu and ex_redirect asserted together -> ifid_flush=1, idex_flush=1, pc_en=1, stall_count unchanged.
- id_halt=1, id_valid=1 at cycle 10, DRAIN_CYCLES=3:
  - DRAIN in cycles 11-13, halted=1 at cycle 14;
  - pc_en stays 0 while random inputs are driven afterwards.
- id_halt with ex_redirect in the same cycle -> stays RUN, halted never rises. Reset at cycle 12 of a halt drain -> RUN at 13, stall_count=0.
- CNT_W=4 with 20 consecutive distinct load-use hazards -> stall_count=15 and holds.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline control types and constants
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int DEFAULT_DRAIN_CYCLES = 3;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard comparison between ID sources and EX load destination
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    output logic       lu
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
        // x0 is hardwired to zero, so a load targeting it never creates a dependency
        lu = id_valid && ex_memread && (ex_rd != REG_X0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/hazard_halt_unit.sv
// rtl/hazard_halt_unit.sv - load-use stall, redirect flush and halt drain sequencing
module hazard_halt_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_halt,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int              DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             lu;

    hazard_detect u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .lu          (lu)
    );

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        stall_d    = stall_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b1;
        halted     = 1'b0;

        if (reset) begin
            ifid_flush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    // A redirect means the ID instruction is wrong-path: its hazards and halt do not count
                    if (ex_redirect) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                    end else if (lu) begin
                        if (stall_q != CNT_MAX) begin
                            stall_d = stall_q + 1'b1;
                        end
                    end else if (id_valid && id_halt) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_flush = 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_d = HALTED;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            drain_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_halt_unit.sv
// tb/tb_hazard_halt_unit.sv - randomized self-checking bench for hazard_halt_unit
module tb_hazard_halt_unit;
    import pipe_ctrl_pkg::*;

    localparam int DC0 = DEFAULT_DRAIN_CYCLES;
    localparam int DC1 = 1;

    logic       clk = 1'b0;
    logic       reset, id_valid, id_halt, id_uses_rs1, id_uses_rs2, ex_memread, ex_redirect;
    logic [4:0] id_rs1, id_rs2, ex_rd;

    logic        pc_en0, ifid_en0, ifid_flush0, idex_flush0, halted0;
    logic        pc_en1, ifid_en1, ifid_flush1, idex_flush1, halted1;
    logic [15:0] sc0;
    logic [3:0]  sc1;
    wire  [4:0]  obs0 = {pc_en0, ifid_en0, ifid_flush0, idex_flush0, halted0};
    wire  [4:0]  obs1 = {pc_en1, ifid_en1, ifid_flush1, idex_flush1, halted1};

    int total = 0;
    int bad   = 0;

    // Reference state: drain cycles still to issue, halted flag, stall tally
    int drain_left[2];
    bit halt_m[2];
    int stalls[2];
    int dcs[2]  = '{DC0, DC1};
    int smax[2] = '{65535, 15};

    logic [4:0] e0, e1;
    int         es0, es1;

    always #5 clk = ~clk;

    hazard_halt_unit #(.DRAIN_CYCLES(DC0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_halt(id_halt),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .pc_en(pc_en0), .ifid_en(ifid_en0), .ifid_flush(ifid_flush0), .idex_flush(idex_flush0),
        .halted(halted0), .stall_count(sc0)
    );

    hazard_halt_unit #(.DRAIN_CYCLES(DC1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_halt(id_halt),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1), .idex_flush(idex_flush1),
        .halted(halted1), .stall_count(sc1)
    );

    function automatic bit ref_lu();
        return id_valid && ex_memread && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    // {pc_en, ifid_en, ifid_flush, idex_flush, halted}
    function automatic logic [4:0] ref_out(input int k);
        if (reset)                          return 5'b00110;
        if (halt_m[k])                      return 5'b00011;
        if (drain_left[k] > 0)              return 5'b00010;
        if (ex_redirect)                    return 5'b11110;
        if (ref_lu() || (id_valid && id_halt)) return 5'b00010;
        return 5'b11000;
    endfunction

    task automatic ref_commit(input int k);
        if (reset) begin
            drain_left[k] = 0;
            halt_m[k]     = 1'b0;
            stalls[k]     = 0;
        end else if (halt_m[k]) begin
        end else if (drain_left[k] > 0) begin
            drain_left[k]--;
            if (drain_left[k] == 0) halt_m[k] = 1'b1;
        end else if (ex_redirect) begin
        end else if (ref_lu()) begin
            if (stalls[k] < smax[k]) stalls[k]++;
        end else if (id_valid && id_halt) begin
            drain_left[k] = dcs[k];
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit h, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit u1, input bit u2, input bit mr,
                         input logic [4:0] rd, input bit redir);
        reset = r; id_valid = v; id_halt = h; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; ex_memread = mr; ex_rd = rd; ex_redirect = redir;
    endtask

    task automatic idle();
        drive(0, 1, 0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0);
    endtask

    task automatic drive_random(input int reset_odds);
        drive($urandom_range(0, reset_odds) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
    endtask

    task automatic settle();
        @(negedge clk);
        e0 = ref_out(0); e1 = ref_out(1);
        es0 = stalls[0]; es1 = stalls[1];
    endtask

    task automatic tick();
        ref_commit(0); ref_commit(1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 5'd3, 5'd3, 1, 1, 1, 5'd3, 1);
        tick();
        settle();
        total++;
        if (obs0 !== 5'b00110 || obs1 !== 5'b00110)
            $display("FAIL reset_outputs obs0=%b obs1=%b expected=00110", obs0, obs1);
        if (obs0 !== 5'b00110 || obs1 !== 5'b00110) bad++;
        total++;
        if (sc0 !== 16'd0 || sc1 !== 4'd0) begin
            bad++;
            $display("FAIL reset_stall_count sc0=%0d sc1=%0d expected=0", sc0, sc1);
        end
        tick();
    endtask

    task automatic test_load_use();
        drive(0, 1, 0, 5'd5, 5'd9, 1, 0, 1, 5'd5, 0);
        settle();
        total++;
        if (obs0 !== 5'b00010 || obs1 !== 5'b00010) begin
            bad++;
            $display("FAIL load_use_stall obs0=%b obs1=%b expected=00010", obs0, obs1);
        end
        tick();
        drive(0, 1, 0, 5'd5, 5'd9, 1, 0, 0, 5'd0, 0);
        settle();
        total++;
        if (obs0 !== 5'b11000 || sc0 !== 16'd1 || sc1 !== 4'd1) begin
            bad++;
            $display("FAIL load_use_release obs0=%b sc0=%0d sc1=%0d expected=11000 sc=1", obs0, sc0, sc1);
        end
        tick();
    endtask

    task automatic test_no_hazard();
        drive(0, 1, 0, 5'd0, 5'd9, 1, 0, 1, 5'd0, 0);
        settle();
        total++;
        if (obs0 !== 5'b11000 || obs1 !== 5'b11000) begin
            bad++;
            $display("FAIL x0_no_stall obs0=%b obs1=%b expected=11000", obs0, obs1);
        end
        tick();
        drive(0, 1, 0, 5'd5, 5'd9, 0, 0, 1, 5'd5, 0);
        settle();
        total++;
        if (obs0 !== 5'b11000 || sc0 !== 16'd1) begin
            bad++;
            $display("FAIL unused_rs_no_stall obs0=%b sc0=%0d expected=11000 sc=1", obs0, sc0);
        end
        tick();
    endtask

    task automatic test_redirect_priority();
        drive(0, 1, 1, 5'd7, 5'd7, 1, 1, 1, 5'd7, 1);
        settle();
        total++;
        if (obs0 !== 5'b11110 || obs1 !== 5'b11110) begin
            bad++;
            $display("FAIL redirect_over_lu obs0=%b obs1=%b expected=11110", obs0, obs1);
        end
        tick();
        idle();
        settle();
        total++;
        if (sc0 !== 16'd1 || obs0 !== 5'b11000) begin
            bad++;
            $display("FAIL redirect_no_count sc0=%0d obs0=%b expected sc=1 obs=11000", sc0, obs0);
        end
        tick();
    endtask

    task automatic test_halt_drain();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 1, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0);
        settle();
        total++;
        if (obs0 !== 5'b00010) begin
            bad++;
            $display("FAIL halt_accept obs0=%b expected=00010", obs0);
        end
        tick();
        for (int i = 1; i <= 8; i++) begin
            drive_random(1000000);
            reset = 1'b0;
            settle();
            total++;
            if (halted0 !== (i > DC0) || halted1 !== (i > DC1) || pc_en0 !== 1'b0 || ifid_en0 !== 1'b0) begin
                bad++;
                $display("FAIL halt_drain_step%0d halted0=%b halted1=%b pc_en0=%b ifid_en0=%b expected halted0=%b halted1=%b pc_en=0",
                         i, halted0, halted1, pc_en0, ifid_en0, i > DC0, i > DC1);
            end
            total++;
            if (obs0 !== e0 || obs1 !== e1) begin
                bad++;
                $display("FAIL halt_drain_model%0d obs0=%b obs1=%b expected %b %b", i, obs0, obs1, e0, e1);
            end
            tick();
        end
    endtask

    task automatic test_halt_redirect();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 1, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            idle();
            settle();
            total++;
            if (obs0 !== 5'b11000 || obs1 !== 5'b11000) begin
                bad++;
                $display("FAIL halt_with_redirect%0d obs0=%b obs1=%b expected=11000", i, obs0, obs1);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 5'd4, 5'd0, 1, 0, 1, 5'd4, 0);
        tick();
        drive(0, 1, 1, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0);
        tick();
        idle();
        tick();
        drive(1, 1, 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0);
        settle();
        total++;
        if (obs0 !== 5'b00110 || sc0 !== 16'd1) begin
            bad++;
            $display("FAIL reset_in_drain obs0=%b sc0=%0d expected=00110 sc=1", obs0, sc0);
        end
        tick();
        idle();
        settle();
        total++;
        if (obs0 !== 5'b11000 || obs1 !== 5'b11000 || sc0 !== 16'd0) begin
            bad++;
            $display("FAIL run_after_reset obs0=%b obs1=%b sc0=%0d expected=11000 sc=0", obs0, obs1, sc0);
        end
        tick();
    endtask

    task automatic test_saturation();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 1; i <= 20; i++) begin
            drive(0, 1, 0, 5'd0, 5'(i), 0, 1, 1, 5'(i), 0);
            settle();
            total++;
            if (obs0 !== 5'b00010) begin
                bad++;
                $display("FAIL sat_stall%0d obs0=%b expected=00010", i, obs0);
            end
            tick();
        end
        idle();
        settle();
        total++;
        if (sc1 !== 4'd15 || sc0 !== 16'd20) begin
            bad++;
            $display("FAIL stall_saturate sc1=%0d sc0=%0d expected sc1=15 sc0=20", sc1, sc0);
        end
        tick();
        drive(0, 1, 0, 5'd3, 5'd0, 1, 0, 1, 5'd3, 0);
        tick();
        idle();
        settle();
        total++;
        if (sc1 !== 4'd15 || sc0 !== 16'd21) begin
            bad++;
            $display("FAIL stall_hold sc1=%0d sc0=%0d expected sc1=15 sc0=21", sc1, sc0);
        end
        tick();
    endtask

    task automatic test_random();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 600; i++) begin
            drive_random(40);
            settle();
            total++;
            if (obs0 !== e0 || sc0 !== es0[15:0]) begin
                bad++;
                $display("FAIL random0_c%0d obs=%b sc=%0d expected obs=%b sc=%0d", i, obs0, sc0, e0, es0);
            end
            total++;
            if (obs1 !== e1 || sc1 !== es1[3:0]) begin
                bad++;
                $display("FAIL random1_c%0d obs=%b sc=%0d expected obs=%b sc=%0d", i, obs1, sc1, e1, es1);
            end
            tick();
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect_priority();
        test_halt_drain();
        test_halt_redirect();
        test_reset_mid_drain();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
